fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port branch_judge  input  1  taken-branch result from the branch comparator.
REQ-005 SHALL have port branch_target  input  32  branch destination, valid when branch_judge=1.
REQ-006 SHALL have port jump  input  1  unconditional jump (jal/jalr) redirect request.
REQ-007 SHALL have port jump_target  input  32  jump destination, valid when jump=1.
REQ-008 SHALL have port imem_req  output  1  instruction-memory request valid.
REQ-009 SHALL have port imem_addr  output  32  instruction-memory request address.
REQ-010 SHALL have port imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-011 SHALL have port imem_rvalid  input  1  read data valid, one per granted request, 1+ cycles after grant.
REQ-012 SHALL have port imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-013 SHALL have port if_valid  output  1  fetched instruction available to decode.
REQ-014 SHALL have port if_pc  output  32  address of the held instruction.
REQ-015 SHALL have port if_inst  output  32  held instruction word.
REQ-016 SHALL have port if_ready  input  1  decode accepts instruction when if_valid=1.

Function
REQ-017 SHALL keep registers pc (next address to request), req_pc (address of outstanding request), kill flag, and state.
REQ-018 SHALL define redirect = branch_judge | jump; redirect target = branch_target if branch_judge=1, else jump_target (branch priority when both are asserted).
REQ-019 SHALL clear bits [1:0] of every redirect target before loading pc.
REQ-020 SHALL implement states S_REQ, S_WAIT, S_HOLD.
REQ-021 In S_REQ: imem_req=1, imem_addr=pc; on imem_gnt -> S_WAIT, req_pc<=pc, kill<=redirect; pc<=target if redirect, else pc+4.
REQ-022 In S_REQ without imem_gnt: stay S_REQ; on redirect pc<=target, so the address changes the following cycle.
REQ-023 In S_WAIT: imem_req=0; on redirect pc<=target and kill<=1.
REQ-024 In S_WAIT on imem_rvalid with kill=0 and no redirect that cycle: if_inst<=imem_rdata, if_pc<=req_pc, if_valid<=1 -> S_HOLD.
REQ-025 In S_WAIT on imem_rvalid with kill=1 or redirect that cycle: discard data, kill<=0 -> S_REQ, if_valid stays 0.
REQ-026 In S_HOLD: if_valid=1, if_pc and if_inst stable; on redirect if_valid<=0 -> S_REQ; else on if_ready if_valid<=0 -> S_REQ; else hold.
REQ-027 SHALL ignore imem_rvalid in S_REQ and S_HOLD.
REQ-028 pc+4 SHALL be 32-bit modular: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-029 Latency: imem_rvalid in cycle N (clean) -> if_valid=1 in cycle N+1; redirect in cycle N -> imem_addr=target no earlier than N+1.

Reset
REQ-030 On rst_n=0, asynchronously: state=S_REQ, pc=RESET_PC, req_pc=RESET_PC, kill=0, if_valid=0, if_pc=0, if_inst=32'h0000_0013 (nop).
REQ-031 While rst_n=0, imem_req SHALL be 0; the first request with imem_addr=RESET_PC SHALL appear in the first cycle after deassertion.
REQ-032 Reset mid-transaction SHALL abandon the outstanding request; any rvalid for it after reset SHALL be ignored (state S_REQ).

Structure
REQ-033 The state encoding typedef, the NOP constant 32'h0000_0013, and the default RESET_PC SHALL live in the shared core package riscv_pkg.
REQ-034 SHALL be a single module with no sub-modules; the FSM, pc register and output register are inline.

Verification
REQ-035 Reset release, imem_gnt=1, rvalid 1 cycle later, if_ready=1 -> requests to 0x0, 0x4, 0x8 in order; if_pc matches each.
REQ-036 branch_judge=1, branch_target=0x100 during S_WAIT for 0x8 -> rdata for 0x8 discarded, if_valid never asserts for it, next imem_addr=0x100.
REQ-037 branch_judge=1 (0x200) and jump=1 (0x300) in the same cycle -> next request 0x200.
REQ-038 if_ready=0 for 5 cycles in S_HOLD -> if_valid, if_pc, if_inst constant; imem_req=0 throughout.
REQ-039 jump_target=0x0000_0106 -> imem_addr=0x0000_0104; pc at 0xFFFF_FFFC with a clean fetch -> next request 0x0000_0000.
REQ-040 rst_n low while in S_WAIT -> outputs take reset values immediately; a late rvalid is ignored; the first request after release is RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM encoding, canonical NOP and the boot address.
package riscv_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Instructions are word aligned; low address bits of any redirect are dropped.
   function automatic logic [31:0] align4(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, redirect on branch/jump,
// and a single-entry output register toward decode.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_judge,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        if_ready
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_pc_q, req_pc_d;
   logic         kill_q, kill_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic [31:0]  if_inst_q, if_inst_d;

   logic         redirect;
   logic [31:0]  target;

   // Branch wins over jump when both fire in the same cycle.
   assign redirect = branch_judge | jump;
   assign target   = align4(branch_judge ? branch_target : jump_target);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      case (state_q)
         S_REQ: begin
            if (imem_gnt) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
               kill_d   = redirect;
               pc_d     = redirect ? target : pc_q + 32'd4;
            end else if (redirect) begin
               pc_d = target;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d   = target;
               kill_d = 1'b1;
            end
            if (imem_rvalid) begin
               if (kill_q || redirect) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  if_inst_d  = imem_rdata;
                  if_pc_d    = req_pc_q;
                  if_valid_d = 1'b1;
                  state_d    = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d       = target;
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end else if (if_ready) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         kill_q     <= 1'b0;
         if_valid_q <= 1'b0;
         if_pc_q    <= 32'h0000_0000;
         if_inst_q  <= NOP_INST;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   // Request is gated by reset so nothing is issued while the core is held.
   assign imem_req  = rst_n & (state_q == S_REQ);
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;

endmodule
